// File: rtl/fir_filter_unit.sv
// rtl/fir_filter_unit.sv - time-multiplexed 15-tap symmetric low-pass FIR, one MAC reused per sample frame
// Optional FIR_SYM_FOLD_EN: fold mirrored taps through a pre-adder, 8 MAC cycles per frame instead of 15
module fir_filter_unit #(
  parameter int FRAME_CYCLES = 20,
  parameter int DW           = 8,
  parameter int ACCW         = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] input_sig,
  input  logic                 ready,
  output logic signed [DW-1:0] filtred_sig
);

  localparam int NTAPS = 15;
  localparam int FCW   = $clog2(FRAME_CYCLES);
  localparam int SW    = ACCW - 6;
`ifdef FIR_SYM_FOLD_EN
  localparam int MAC_CYCLES = 8;
  localparam int PW         = DW + 9;
`else
  localparam int MAC_CYCLES = NTAPS;
  localparam int PW         = DW + 8;
`endif

  localparam logic [FCW-1:0]       FC_LAST    = FCW'(FRAME_CYCLES - 1);
  localparam logic [FCW-1:0]       FC_MAC_END = FCW'(MAC_CYCLES);
  localparam logic signed [SW-1:0] SAT_HI     = SW'((2 ** (DW - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_LO     = SW'(-(2 ** (DW - 1)));

  // Q1.7 coefficients, DC gain 128/128
  function automatic logic signed [7:0] coef(input logic [3:0] k);
    logic signed [7:0] h;
    case (k)
      4'd1, 4'd2, 4'd12, 4'd13: h = -8'sd1;
      4'd3, 4'd11:              h = 8'sd2;
      4'd4, 4'd10:              h = 8'sd8;
      4'd5, 4'd9:               h = 8'sd17;
      4'd6, 4'd8:               h = 8'sd25;
      4'd7:                     h = 8'sd28;
      default:                  h = 8'sd0;
    endcase
    return h;
  endfunction

  logic [FCW-1:0]         fc;
  logic signed [DW-1:0]   x [0:NTAPS-1];
  logic signed [ACCW-1:0] acc;

  logic                   mac_en;
  logic [3:0]             tap_idx;
  logic signed [7:0]      h_k;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] mac_term;
`ifdef FIR_SYM_FOLD_EN
  logic signed [DW-1:0]   x_a;
  logic signed [DW-1:0]   x_b;
  logic signed [DW:0]     pre;
`endif

  always_comb begin
    mac_en  = (fc != '0) && (fc <= FC_MAC_END);
    tap_idx = mac_en ? 4'(fc - FCW'(1)) : 4'd0;
    h_k     = coef(tap_idx);
`ifdef FIR_SYM_FOLD_EN
    // centre tap has no mirror partner, so it enters the pre-adder alone
    x_a  = x[tap_idx];
    x_b  = (tap_idx == 4'd7) ? '0 : x[4'd14 - tap_idx];
    pre  = {x_a[DW-1], x_a} + {x_b[DW-1], x_b};
    prod = h_k * pre;
`else
    prod = h_k * x[tap_idx];
`endif
    mac_term = mac_en ? {{(ACCW - PW){prod[PW-1]}}, prod} : '0;
  end

  logic signed [ACCW:0]   rounded;
  logic signed [SW-1:0]   scaled;
  logic signed [DW-1:0]   sat_val;

  always_comb begin
    rounded = {acc[ACCW-1], acc} + (ACCW + 1)'(64);
    scaled  = SW'(rounded >>> 7);
    if (scaled > SAT_HI)
      sat_val = DW'(SAT_HI);
    else if (scaled < SAT_LO)
      sat_val = DW'(SAT_LO);
    else
      sat_val = DW'(scaled);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc          <= '0;
      acc         <= '0;
      filtred_sig <= '0;
      for (int i = 0; i < NTAPS; i++) x[i] <= '0;
    end else if (!ready) begin
      // dropping ready abandons any partial frame; the next frame restarts at capture
      fc <= '0;
    end else begin
      fc <= (fc == FC_LAST) ? '0 : fc + FCW'(1);
      if (fc == '0) begin
        for (int i = NTAPS - 1; i > 0; i--) x[i] <= x[i-1];
        x[0] <= input_sig;
        acc  <= '0;
      end else begin
        acc <= acc + mac_term;
      end
      if (fc == FC_LAST) filtred_sig <= sat_val;
    end
  end

endmodule

// File: tb/tb_fir_filter_unit.sv
// tb/tb_fir_filter_unit.sv - directed self-checking bench for fir_filter_unit
// Expected values are hand-computed from the Q1.7 coefficient set; identical for FIR_SYM_FOLD_EN builds.
module tb_fir_filter_unit;

  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [7:0] input_sig;
  logic              ready;
  logic signed [7:0] filtred_sig;

  int checks   = 0;
  int failures = 0;

  logic signed [7:0] imp_exp [0:15] = '{8'sd0, -8'sd1, -8'sd1, 8'sd2, 8'sd8, 8'sd17, 8'sd25, 8'sd28,
                                        8'sd25, 8'sd17, 8'sd8, 8'sd2, -8'sd1, -8'sd1, 8'sd0, 8'sd0};

  fir_filter_unit #(.FRAME_CYCLES(20), .DW(8), .ACCW(18)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .input_sig   (input_sig),
    .ready       (ready),
    .filtred_sig (filtred_sig)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [7:0] obs, input logic signed [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one full frame: capture on the next edge, output settles 19 edges later
  task automatic run_frame(input logic signed [7:0] s);
    input_sig = s;
    ready     = 1'b1;
    tick(20);
  endtask

  initial begin
    logic signed [7:0] s;
    rst_n     = 1'b0;
    ready     = 1'b0;
    input_sig = 8'sd0;
    tick(3);
    check("reset", filtred_sig, 8'sd0);
    rst_n = 1'b1;
    tick(2);

    // impulse response, with exact latency observed on the second frame
    run_frame(8'sd127);
    check("impulse[0]", filtred_sig, imp_exp[0]);
    input_sig = 8'sd0;
    tick(19);
    check("latency_hold", filtred_sig, 8'sd0);
    tick(1);
    check("impulse[1]", filtred_sig, imp_exp[1]);
    for (int i = 2; i < 16; i++) begin
      run_frame(8'sd0);
      check($sformatf("impulse[%0d]", i), filtred_sig, imp_exp[i]);
    end

    // DC step of 100 from an empty delay line
    for (int i = 1; i <= 16; i++) begin
      run_frame(8'sd100);
      if (i == 2)  check("dc100_f2", filtred_sig, -8'sd1);
      if (i == 8)  check("dc100_f8", filtred_sig, 8'sd61);
      if (i == 15) check("dc100_f15", filtred_sig, 8'sd100);
      if (i == 16) check("dc100_f16", filtred_sig, 8'sd100);
    end

    for (int i = 1; i <= 15; i++) run_frame(-8'sd128);
    check("dc_neg128", filtred_sig, -8'sd128);

    // worst-case accumulation: +127 on non-negative taps, -128 on negative taps
    for (int i = 0; i < 15; i++) begin
      s = ((14 - i) inside {1, 2, 12, 13}) ? -8'sd128 : 8'sd127;
      run_frame(s);
    end
    check("saturate", filtred_sig, 8'sd127);

    // ready drop part-way through a frame: no output update, restart from capture
    input_sig = 8'sd0;
    ready     = 1'b1;
    tick(11);
    ready = 1'b0;
    tick(20);
    check("ready_drop_hold", filtred_sig, 8'sd127);
    run_frame(8'sd0);
    check("ready_restart", filtred_sig, 8'sd108);

    // asynchronous reset mid-frame clears output at once and empties the delay line
    input_sig = 8'sd127;
    ready     = 1'b1;
    tick(5);
    rst_n = 1'b0;
    #2;
    check("async_reset", filtred_sig, 8'sd0);
    ready     = 1'b0;
    input_sig = 8'sd0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    run_frame(8'sd127);
    check("reimpulse[0]", filtred_sig, imp_exp[0]);
    for (int i = 1; i < 16; i++) begin
      run_frame(8'sd0);
      check($sformatf("reimpulse[%0d]", i), filtred_sig, imp_exp[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
